exp_mailbox: RTL and testbench

Expansion-port I/O responder: a byte mailbox between the emulated CPC CPU and a host controller (for example the MiST ARM side). It sits on the motherboard expansion bus and decodes Z80 I/O cycles on `cpu_addr`, `iorq`, `rd`, `wr` and `m1`. It returns read data on `cpu_din`, which the motherboard ANDs into the CPU data bus, and can raise `irq`. On the host side it has two FIFOs with valid/ready handshakes: RX carries bytes host→CPU and TX carries bytes CPU→host.

---
 rtl/exp_mailbox.sv | 204 ++++++++++++++++++++
 tb/tb_exp_mailbox.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/exp_mailbox.sv
// Expansion-port byte mailbox between the Z80 I/O space and a host controller.
// Optional registered interrupt on RX data is enabled by defining EXP_MAILBOX_IRQ_EN.
module exp_mailbox #(
   parameter logic [15:0] BASE       = 16'hFBD0,
   parameter int          DEPTH_LOG2 = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_dout,
   output logic [7:0]  cpu_din,
   input  logic        iorq,
   input  logic        rd,
   input  logic        wr,
   input  logic        m1,
   output logic        irq,
   input  logic [7:0]  h_tx_data,
   input  logic        h_tx_valid,
   output logic        h_tx_ready,
   output logic [7:0]  h_rx_data,
   output logic        h_rx_valid,
   input  logic        h_rx_ready
);

   localparam int                    DEPTH    = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [DEPTH_LOG2:0]   CNT_ZERO = '0;
   localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

   // Bus decode and edge registers
   logic sel;
   logic acc_rd;
   logic acc_wr;
   logic acc_rd_q;
   logic acc_wr_q;
   logic rd_arm_q;
   logic idle_seen_q;
   logic wr_edge;
   logic rd_fall;
   logic ctl_wr;

   // FIFO state
   logic [7:0]            rx_mem [DEPTH];
   logic [7:0]            tx_mem [DEPTH];
   logic [DEPTH_LOG2-1:0] rx_wr_ptr;
   logic [DEPTH_LOG2-1:0] rx_rd_ptr;
   logic [DEPTH_LOG2-1:0] tx_wr_ptr;
   logic [DEPTH_LOG2-1:0] tx_rd_ptr;
   logic [DEPTH_LOG2:0]   rx_count;
   logic [DEPTH_LOG2:0]   tx_count;
   logic                  rx_not_empty;
   logic                  tx_not_full;
   logic                  rx_push;
   logic                  rx_pop;
   logic                  tx_push_try;
   logic                  tx_push;
   logic                  tx_pop;

   logic       tx_drop;
   logic       irq_en;
   logic [7:0] status;
   logic       unused_bits;

   assign sel    = iorq & ~m1 & (cpu_addr[15:1] == BASE[15:1]);
   assign acc_rd = sel & rd;
   assign acc_wr = sel & wr;

   // idle_seen_q stays low until the bus has been idle once after reset, so an
   // access already in flight at reset release never pushes or pops.
   assign wr_edge = acc_wr & ~acc_wr_q & idle_seen_q;
   assign rd_fall = acc_rd_q & ~acc_rd & idle_seen_q;
   assign ctl_wr  = wr_edge & cpu_addr[0];

   assign rx_not_empty = (rx_count != CNT_ZERO);
   assign tx_not_full  = (tx_count != CNT_FULL);

   // Host handshakes: a byte moves on any clock where valid and ready are both
   // high; ready/valid come only from registered counts, never from the peer.
   assign h_tx_ready = (rx_count != CNT_FULL);
   assign h_rx_valid = (tx_count != CNT_ZERO);
   assign h_rx_data  = tx_mem[tx_rd_ptr];

   assign rx_push     = h_tx_valid & h_tx_ready;
   assign rx_pop      = rd_fall & rd_arm_q;
   assign tx_push_try = wr_edge & ~cpu_addr[0];
   assign tx_push     = tx_push_try & tx_not_full;
   assign tx_pop      = h_rx_valid & h_rx_ready;

   assign status = {irq_en, 3'b000, tx_drop, 1'b0, tx_not_full, rx_not_empty};

   always_comb begin
      cpu_din = 8'hFF;
      if (acc_rd) begin
         if (cpu_addr[0]) begin
            cpu_din = status;
         end else if (rx_not_empty) begin
            cpu_din = rx_mem[rx_rd_ptr];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         acc_rd_q    <= 1'b0;
         acc_wr_q    <= 1'b0;
         rd_arm_q    <= 1'b0;
         idle_seen_q <= 1'b0;
      end else begin
         acc_rd_q <= acc_rd;
         acc_wr_q <= acc_wr;
         // Pop only what was actually presented on the last clock of the read.
         rd_arm_q <= acc_rd & ~cpu_addr[0] & rx_not_empty;
         if (!acc_rd && !acc_wr) begin
            idle_seen_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rx_push) begin
         rx_mem[rx_wr_ptr] <= h_tx_data;
      end
      if (tx_push) begin
         tx_mem[tx_wr_ptr] <= cpu_dout;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rx_wr_ptr <= '0;
         rx_rd_ptr <= '0;
         rx_count  <= '0;
      end else begin
         if (rx_push) begin
            rx_wr_ptr <= rx_wr_ptr + PTR_ONE;
         end
         if (rx_pop) begin
            rx_rd_ptr <= rx_rd_ptr + PTR_ONE;
         end
         case ({rx_push, rx_pop})
            2'b10:   rx_count <= rx_count + CNT_ONE;
            2'b01:   rx_count <= rx_count - CNT_ONE;
            default: rx_count <= rx_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         tx_wr_ptr <= '0;
         tx_rd_ptr <= '0;
         tx_count  <= '0;
      end else begin
         if (tx_push) begin
            tx_wr_ptr <= tx_wr_ptr + PTR_ONE;
         end
         if (tx_pop) begin
            tx_rd_ptr <= tx_rd_ptr + PTR_ONE;
         end
         case ({tx_push, tx_pop})
            2'b10:   tx_count <= tx_count + CNT_ONE;
            2'b01:   tx_count <= tx_count - CNT_ONE;
            default: tx_count <= tx_count;
         endcase
      end
   end

   // Full is judged on the registered count, so a same-cycle host pop cannot
   // rescue a CPU write into a full TX FIFO.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         tx_drop <= 1'b0;
      end else if (ctl_wr && cpu_dout[3]) begin
         tx_drop <= 1'b0;
      end else if (tx_push_try && !tx_not_full) begin
         tx_drop <= 1'b1;
      end
   end

`ifdef EXP_MAILBOX_IRQ_EN
   logic irq_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         irq_en <= 1'b0;
         irq_q  <= 1'b0;
      end else begin
         if (ctl_wr) begin
            irq_en <= cpu_dout[7];
         end
         irq_q <= irq_en & rx_not_empty;
      end
   end

   assign irq = irq_q;
`else
   assign irq_en = 1'b0;
   assign irq    = 1'b0;
`endif

   assign unused_bits = &{1'b0, cpu_dout};

endmodule

// File: tb/tb_exp_mailbox.sv
// Directed self-checking bench for exp_mailbox: bus reads/writes, host FIFO
// handshakes, full/empty boundaries, m1 exclusion and reset-release behaviour.
module tb_exp_mailbox;

   logic        clk;
   logic        reset_n;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_dout;
   logic [7:0]  cpu_din;
   logic        iorq;
   logic        rd;
   logic        wr;
   logic        m1;
   logic        irq;
   logic [7:0]  h_tx_data;
   logic        h_tx_valid;
   logic        h_tx_ready;
   logic [7:0]  h_rx_data;
   logic        h_rx_valid;
   logic        h_rx_ready;

   int checks   = 0;
   int failures = 0;
   logic [7:0] exp_q[$];
   logic [7:0] exp_b;

`ifdef EXP_MAILBOX_IRQ_EN
   localparam logic       IRQ_ON   = 1'b1;
   localparam logic [7:0] IRQ_STAT = 8'h80;
`else
   localparam logic       IRQ_ON   = 1'b0;
   localparam logic [7:0] IRQ_STAT = 8'h00;
`endif

   exp_mailbox dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .cpu_addr   (cpu_addr),
      .cpu_dout   (cpu_dout),
      .cpu_din    (cpu_din),
      .iorq       (iorq),
      .rd         (rd),
      .wr         (wr),
      .m1         (m1),
      .irq        (irq),
      .h_tx_data  (h_tx_data),
      .h_tx_valid (h_tx_valid),
      .h_tx_ready (h_tx_ready),
      .h_rx_data  (h_rx_data),
      .h_rx_valid (h_rx_valid),
      .h_rx_ready (h_rx_ready)
   );

   // Clock and watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Read held for 'cycles' clocks, checked every clock; returns just after
   // the clock that sees the strobe fall.
   task automatic io_rd(input logic [15:0] addr, input int cycles,
                        input logic [7:0] exp, input string tag);
      cpu_addr = addr;
      iorq     = 1'b1;
      rd       = 1'b1;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         check(tag, cpu_din, exp);
         tick();
      end
      iorq = 1'b0;
      rd   = 1'b0;
      tick();
   endtask

   task automatic io_wr(input logic [15:0] addr, input logic [7:0] data);
      cpu_addr = addr;
      cpu_dout = data;
      iorq     = 1'b1;
      wr       = 1'b1;
      tick();
      iorq = 1'b0;
      wr   = 1'b0;
      tick();
   endtask

   task automatic host_push(input logic [7:0] data);
      @(negedge clk);
      check("host_push_ready", {7'd0, h_tx_ready}, 8'h01);
      @(posedge clk);
      #1;
      h_tx_valid = 1'b1;
      h_tx_data  = data;
      tick();
      h_tx_valid = 1'b0;
   endtask

   initial begin
      reset_n    = 1'b0;
      cpu_addr   = 16'h0000;
      cpu_dout   = 8'h00;
      iorq       = 1'b0;
      rd         = 1'b0;
      wr         = 1'b0;
      m1         = 1'b0;
      h_tx_data  = 8'h00;
      h_tx_valid = 1'b0;
      h_rx_ready = 1'b0;
      repeat (3) tick();
      reset_n = 1'b1;
      tick();

      // Reset state
      @(negedge clk);
      check("reset_cpu_din", cpu_din, 8'hFF);
      check("reset_h_tx_ready", {7'd0, h_tx_ready}, 8'h01);
      check("reset_h_rx_valid", {7'd0, h_rx_valid}, 8'h00);
      check("reset_irq", {7'd0, irq}, 8'h00);
      tick();
      io_rd(16'hFBD1, 1, 8'h02, "reset_status");

      // Host to CPU, held read pops once
      host_push(8'h41);
      host_push(8'h42);
      io_rd(16'hFBD0, 4, 8'h41, "rd_hold_41");
      io_rd(16'hFBD0, 1, 8'h42, "rd_42");
      io_rd(16'hFBD0, 1, 8'hFF, "rd_empty");
      io_rd(16'hFBD1, 1, 8'h02, "status_rx_drained");

      // CPU to host, overflow on the 17th byte
      h_rx_ready = 1'b0;
      for (int i = 0; i < 17; i++) begin
         io_wr(16'hFBD0, 8'(i));
         if (i < 16) exp_q.push_back(8'(i));
      end
      @(negedge clk);
      check("tx_valid_full", {7'd0, h_rx_valid}, 8'h01);
      tick();
      io_rd(16'hFBD1, 1, 8'h08, "status_drop");
      h_rx_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         check("tx_drain_valid", {7'd0, h_rx_valid}, 8'h01);
         exp_b = exp_q.pop_front();
         check("tx_drain_data", h_rx_data, exp_b);
         tick();
      end
      h_rx_ready = 1'b0;
      @(negedge clk);
      check("tx_empty_after_drain", {7'd0, h_rx_valid}, 8'h00);
      check("tx_scoreboard_empty", 8'(exp_q.size()), 8'h00);
      tick();
      io_rd(16'hFBD1, 1, 8'h0A, "status_drop_sticky");
      io_wr(16'hFBD1, 8'h08);
      io_rd(16'hFBD1, 1, 8'h02, "status_drop_cleared");

      // RX full: pop and host push in the same cycle
      for (int i = 0; i < 16; i++) begin
         host_push(8'h80 + 8'(i));
         exp_q.push_back(8'h80 + 8'(i));
      end
      @(negedge clk);
      check("rx_full_ready", {7'd0, h_tx_ready}, 8'h00);
      tick();
      io_rd(16'hFBD1, 1, 8'h03, "status_rx_full");
      cpu_addr = 16'hFBD0;
      iorq     = 1'b1;
      rd       = 1'b1;
      @(negedge clk);
      check("rx_full_head", cpu_din, 8'h80);
      tick();
      iorq       = 1'b0;
      rd         = 1'b0;
      h_tx_valid = 1'b1;
      h_tx_data  = 8'hA5;
      @(negedge clk);
      check("full_refuse_on_pop", {7'd0, h_tx_ready}, 8'h00);
      tick();
      exp_b = exp_q.pop_front();
      @(negedge clk);
      check("ready_after_pop", {7'd0, h_tx_ready}, 8'h01);
      tick();
      h_tx_valid = 1'b0;
      exp_q.push_back(8'hA5);
      @(negedge clk);
      check("rx_refull_ready", {7'd0, h_tx_ready}, 8'h00);
      tick();
      for (int i = 0; i < 16; i++) begin
         exp_b = exp_q.pop_front();
         io_rd(16'hFBD0, 1, exp_b, "rx_drain");
      end
      io_rd(16'hFBD1, 1, 8'h02, "status_rx_empty");

      // Interrupt enable, m1 exclusion, irq timing
      io_wr(16'hFBD1, 8'h80);
      host_push(8'h55);
      @(negedge clk);
      check("irq_not_yet", {7'd0, irq}, 8'h00);
      tick();
      @(negedge clk);
      check("irq_after_push", {7'd0, irq}, {7'd0, IRQ_ON});
      tick();
      cpu_addr = 16'hFBD0;
      m1       = 1'b1;
      iorq     = 1'b1;
      rd       = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("m1_no_drive", cpu_din, 8'hFF);
         tick();
      end
      m1   = 1'b0;
      iorq = 1'b0;
      rd   = 1'b0;
      tick();
      io_rd(16'hFBD1, 1, IRQ_STAT | 8'h03, "status_after_m1");
      io_rd(16'hFBD0, 1, 8'h55, "rd_irq_byte");
      @(negedge clk);
      check("irq_on_pop_clock", {7'd0, irq}, {7'd0, IRQ_ON});
      tick();
      @(negedge clk);
      check("irq_after_pop", {7'd0, irq}, 8'h00);
      tick();
      io_rd(16'hFBD1, 1, IRQ_STAT | 8'h02, "status_irq_en");

      // Write in progress across reset release must not push
      reset_n  = 1'b0;
      cpu_addr = 16'hFBD0;
      cpu_dout = 8'h77;
      iorq     = 1'b1;
      wr       = 1'b1;
      repeat (2) tick();
      reset_n = 1'b1;
      repeat (2) tick();
      iorq = 1'b0;
      wr   = 1'b0;
      tick();
      @(negedge clk);
      check("reset_release_no_push", {7'd0, h_rx_valid}, 8'h00);
      tick();
      io_rd(16'hFBD1, 1, 8'h02, "status_after_reset");
      io_wr(16'hFBD0, 8'h99);
      @(negedge clk);
      check("post_reset_push_valid", {7'd0, h_rx_valid}, 8'h01);
      check("post_reset_push_data", h_rx_data, 8'h99);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
